// File: rtl/wb_spi_sram.sv
// Wishbone slave bridging byte accesses to a 24-bit-addressed serial SRAM over SPI mode 0.
// Incrementing linear bursts keep chip-select low and stream further data bytes only.
module wb_spi_sram #(
  parameter int         ADDR_WIDTH     = 24,
  parameter int         DATA_WIDTH     = 8,
  parameter logic [7:0] READ_CMD       = 8'h03,
  parameter logic [7:0] WRITE_CMD      = 8'h02,
  parameter int         CS_HIGH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic                  wb_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int         SW         = 8 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [5:0] FULL_BITS  = 6'(SW);
  localparam logic [5:0] DATA_BITS  = 6'(DATA_WIDTH);
  localparam logic [7:0] DESEL_LOAD = 8'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, ACK, BURST_WAIT, DESELECT} state_t;

  state_t                state, state_n;
  logic [5:0]            cnt, cnt_n;
  logic                  ph, ph_n;
  logic [7:0]            dcnt, dcnt_n;
  logic [SW-1:0]         sh, sh_n;
  logic [DATA_WIDTH-1:0] rx, rx_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] adr_q, adr_n;
  logic                  cont_q, cont_n;
  logic                  desel;
  logic                  ack_n, err_n, sck_n, cs_n_n, mosi_n;
  logic [DATA_WIDTH-1:0] dat_n;
  logic                  req, burst_type;

  assign req        = wb_cyc_i & wb_stb_i;
  assign burst_type = (wb_cti_i == 3'b010) && (wb_bte_i == 2'b00);
  assign wb_rty_o   = 1'b0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    dcnt_n  = dcnt;
    sh_n    = sh;
    rx_n    = rx;
    we_n    = we_q;
    adr_n   = adr_q;
    cont_n  = cont_q;
    desel   = 1'b0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    sck_n   = 1'b0;
    cs_n_n  = spi_cs_n_o;
    mosi_n  = spi_mosi_o;
    dat_n   = '0;
    case (state)
      IDLE: begin
        // err_o is registered, so skip the cycle it is showing to avoid a double pulse
        if (req && !wb_err_o) begin
          if (!wb_sel_i) begin
            err_n = 1'b1;
          end else begin
            we_n    = wb_we_i;
            adr_n   = wb_adr_i;
            cont_n  = burst_type;
            sh_n    = {(wb_we_i ? WRITE_CMD : READ_CMD), wb_adr_i,
                       (wb_we_i ? wb_dat_i : {DATA_WIDTH{1'b0}})};
            cnt_n   = FULL_BITS;
            ph_n    = 1'b0;
            cs_n_n  = 1'b0;
            mosi_n  = sh_n[SW-1];
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!wb_cyc_i) begin
          desel = 1'b1;
        end else if (!ph) begin
          sck_n = 1'b1;
          ph_n  = 1'b1;
        end else begin
          rx_n  = {rx[DATA_WIDTH-2:0], spi_miso_i};
          sh_n  = {sh[SW-2:0], 1'b0};
          ph_n  = 1'b0;
          cnt_n = cnt - 6'd1;
          if (cnt == 6'd1) begin
            ack_n   = 1'b1;
            dat_n   = we_q ? {DATA_WIDTH{1'b0}} : rx_n;
            state_n = ACK;
          end else begin
            mosi_n = sh[SW-2];
          end
        end
      end
      ACK: begin
        // burst decision uses the cycle type latched with the acked beat
        if (cont_q && (adr_q != {ADDR_WIDTH{1'b1}})) state_n = BURST_WAIT;
        else desel = 1'b1;
      end
      BURST_WAIT: begin
        if (!wb_cyc_i) begin
          desel = 1'b1;
        end else if (wb_stb_i) begin
          if (wb_sel_i && (wb_we_i == we_q) && (wb_adr_i == adr_q + 1'b1)) begin
            adr_n   = wb_adr_i;
            cont_n  = burst_type;
            sh_n    = {(wb_we_i ? wb_dat_i : {DATA_WIDTH{1'b0}}), {(SW-DATA_WIDTH){1'b0}}};
            cnt_n   = DATA_BITS;
            ph_n    = 1'b0;
            mosi_n  = sh_n[SW-1];
            state_n = SHIFT;
          end else begin
            desel = 1'b1;
          end
        end
      end
      DESELECT: begin
        // the IDLE cycle that follows is also spent with cs_n high
        if (dcnt <= 8'd1) state_n = IDLE;
        else dcnt_n = dcnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
    if (desel) begin
      state_n = DESELECT;
      cs_n_n  = 1'b1;
      mosi_n  = 1'b0;
      sck_n   = 1'b0;
      dcnt_n  = DESEL_LOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      ph         <= 1'b0;
      dcnt       <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
      spi_sck_o  <= 1'b0;
      spi_cs_n_o <= 1'b1;
      spi_mosi_o <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ph         <= ph_n;
      dcnt       <= dcnt_n;
      wb_ack_o   <= ack_n;
      wb_err_o   <= err_n;
      wb_dat_o   <= dat_n;
      spi_sck_o  <= sck_n;
      spi_cs_n_o <= cs_n_n;
      spi_mosi_o <= mosi_n;
    end
  end

  always_ff @(posedge clk_i) begin
    sh     <= sh_n;
    rx     <= rx_n;
    we_q   <= we_n;
    adr_q  <= adr_n;
    cont_q <= cont_n;
  end

endmodule

// File: tb/tb_wb_spi_sram.sv
// Directed bench for wb_spi_sram with a behavioural 23LC1024-style sequential-mode SRAM.
module tb_wb_spi_sram;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_sel_i = 1'b0;
  logic [23:0] wb_adr_i = '0;
  logic [7:0]  wb_dat_i = '0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [7:0]  wb_dat_o;
  logic        spi_sck_o, spi_cs_n_o, spi_mosi_o;
  logic        spi_miso_i = 1'b0;

  int checks = 0;
  int failures = 0;

  wb_spi_sram dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
    .spi_sck_o(spi_sck_o), .spi_cs_n_o(spi_cs_n_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: unwritten locations read back their own low address byte
  logic [7:0]  mem [int];
  logic [7:0]  mosi_log [$];
  int          bitc = 0;
  int          cs_rises = 0;
  int          cs_falls = 0;
  logic [7:0]  shin = '0, cmd = '0, outb = '0;
  logic [23:0] maddr = '0, raddr = '0;

  always @(posedge spi_sck_o or posedge spi_cs_n_o) begin
    if (spi_cs_n_o) begin
      bitc = 0;
      cmd = 8'h00;
      cs_rises++;
    end else begin
      shin = {shin[6:0], spi_mosi_o};
      bitc++;
      if (bitc % 8 == 0) begin
        mosi_log.push_back(shin);
        if (bitc == 8) cmd = shin;
        else if (bitc <= 32) maddr = {maddr[15:0], shin};
        else if (cmd == 8'h02) begin
          mem[int'(maddr)] = shin;
          maddr = maddr + 24'd1;
        end
      end
    end
  end

  always @(negedge spi_cs_n_o) cs_falls++;

  always @(negedge spi_sck_o) begin
    if (!spi_cs_n_o && cmd == 8'h03 && bitc >= 32) begin
      if (bitc == 32) raddr = maddr;
      if (bitc % 8 == 0) begin
        outb = mem.exists(int'(raddr)) ? mem[int'(raddr)] : raddr[7:0];
        raddr = raddr + 24'd1;
      end
      spi_miso_i = outb[7];
      outb = {outb[6:0], 1'b0};
    end
  end

  int         k;
  logic       got_ack, got_err;
  logic [7:0] got_dat;
  int         snap, hi;

  task automatic req(input logic we, input logic [23:0] adr, input logic [7:0] dat,
                     input logic [2:0] cti, input logic sel);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_cti_i = cti; wb_bte_i = 2'b00; wb_sel_i = sel;
  endtask

  task automatic idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000; wb_sel_i = 1'b0;
  endtask

  // k = index of the first edge (0 = first edge after the call) followed by ack/err; -1 on timeout
  task automatic wait_resp(input int budget, output int kk, output logic a,
                           output logic e, output logic [7:0] d);
    kk = -1; a = 1'b0; e = 1'b0; d = '0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (wb_ack_o || wb_err_o) begin
        kk = i; a = wb_ack_o; e = wb_err_o; d = wb_dat_o;
        break;
      end
    end
  endtask

  task automatic settle();
    idle();
    repeat (6) @(posedge clk_i);
    #1;
    mosi_log.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (spi_cs_n_o !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", spi_cs_n_o); end
    checks++; if (spi_sck_o !== 1'b0) begin failures++; $display("FAIL rst_sck got=%b exp=0", spi_sck_o); end
    checks++; if (spi_mosi_o !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", spi_mosi_o); end
    checks++; if ({wb_ack_o, wb_err_o, wb_rty_o} !== 3'b000) begin failures++; $display("FAIL rst_ack_err_rty got=%b exp=000", {wb_ack_o, wb_err_o, wb_rty_o}); end
    checks++; if (wb_dat_o !== 8'h00) begin failures++; $display("FAIL rst_dat got=%h exp=00", wb_dat_o); end
    rst_ni = 1'b1;
    settle();
  endtask

  task automatic test_err();
    snap = cs_falls;
    req(1'b0, 24'h000040, 8'h00, 3'b000, 1'b0);
    wait_resp(10, k, got_ack, got_err, got_dat);
    idle();
    checks++; if (got_err !== 1'b1 || k != 0) begin failures++; $display("FAIL err_pulse got=%b@%0d exp=1@0", got_err, k); end
    checks++; if (got_ack !== 1'b0) begin failures++; $display("FAIL err_no_ack got=%b exp=0", got_ack); end
    @(posedge clk_i); #1;
    checks++; if (wb_err_o !== 1'b0) begin failures++; $display("FAIL err_width got=%b exp=0", wb_err_o); end
    checks++; if (spi_cs_n_o !== 1'b1 || cs_falls != snap) begin failures++; $display("FAIL err_cs got=%b falls=%0d exp=1 falls=%0d", spi_cs_n_o, cs_falls, snap); end
    settle();
  endtask

  task automatic test_single_read();
    req(1'b0, 24'h000123, 8'h00, 3'b000, 1'b1);
    wait_resp(200, k, got_ack, got_err, got_dat);
    idle();
    checks++; if (k != 80 || got_ack !== 1'b1) begin failures++; $display("FAIL rd_ack_edge got=%0d exp=80", k); end
    checks++; if (got_dat !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", got_dat); end
    checks++; if ({mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3]} !== 32'h03000123) begin
      failures++; $display("FAIL rd_header got=%h%h%h%h exp=03000123", mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3]); end
    @(posedge clk_i); #1;
    checks++; if (spi_cs_n_o !== 1'b1 || spi_sck_o !== 1'b0) begin failures++; $display("FAIL rd_deselect1 got=%b%b exp=10", spi_cs_n_o, spi_sck_o); end
    @(posedge clk_i); #1;
    checks++; if (spi_cs_n_o !== 1'b1) begin failures++; $display("FAIL rd_deselect2 got=%b exp=1", spi_cs_n_o); end
    settle();
  endtask

  task automatic test_single_write();
    req(1'b1, 24'h012345, 8'h5A, 3'b000, 1'b1);
    wait_resp(200, k, got_ack, got_err, got_dat);
    idle();
    checks++; if (k != 80 || got_ack !== 1'b1) begin failures++; $display("FAIL wr_ack_edge got=%0d exp=80", k); end
    checks++; if (mosi_log.size() != 5) begin failures++; $display("FAIL wr_bytes got=%0d exp=5", mosi_log.size()); end
    checks++; if ({mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4]} !== 40'h020123455A) begin
      failures++; $display("FAIL wr_frame got=%h%h%h%h%h exp=020123455a", mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4]); end
    checks++; if (mem[32'h00012345] !== 8'h5A) begin failures++; $display("FAIL wr_mem got=%h exp=5a", mem[32'h00012345]); end
    wait_resp(20, k, got_ack, got_err, got_dat);
    checks++; if (k != -1) begin failures++; $display("FAIL wr_single_ack got=%0d exp=-1", k); end
    settle();
  endtask

  task automatic test_burst_read();
    req(1'b0, 24'h000010, 8'h00, 3'b010, 1'b1);
    @(posedge clk_i); #1;
    snap = cs_rises;
    for (int n = 0; n < 4; n++) begin
      wait_resp(200, k, got_ack, got_err, got_dat);
      checks++; if (k != ((n == 0) ? 79 : 17)) begin failures++; $display("FAIL burst_ack_edge beat=%0d got=%0d exp=%0d", n, k, (n == 0) ? 79 : 17); end
      checks++; if (got_dat !== 8'(8'h10 + n)) begin failures++; $display("FAIL burst_data beat=%0d got=%h exp=%h", n, got_dat, 8'(8'h10 + n)); end
      if (n < 3) req(1'b0, 24'(24'h000010 + n + 1), 8'h00, (n == 2) ? 3'b111 : 3'b010, 1'b1);
      else idle();
    end
    checks++; if (cs_rises != snap) begin failures++; $display("FAIL burst_cs_low got=%0d rises exp=0", cs_rises - snap); end
    checks++; if (mosi_log.size() != 8) begin failures++; $display("FAIL burst_bytes got=%0d exp=8", mosi_log.size()); end
    checks++; if ({mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3]} !== 32'h03000010) begin
      failures++; $display("FAIL burst_header got=%h%h%h%h exp=03000010", mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3]); end
    @(posedge clk_i); #1;
    checks++; if (spi_cs_n_o !== 1'b1) begin failures++; $display("FAIL burst_end_cs got=%b exp=1", spi_cs_n_o); end
    settle();
  endtask

  task automatic test_nonseq();
    req(1'b0, 24'h000010, 8'h00, 3'b010, 1'b1);
    wait_resp(200, k, got_ack, got_err, got_dat);
    checks++; if (k != 80 || got_dat !== 8'h10) begin failures++; $display("FAIL nonseq_first got=%h@%0d exp=10@80", got_dat, k); end
    req(1'b0, 24'h000020, 8'h00, 3'b111, 1'b1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (spi_cs_n_o) hi++;
      else if (hi > 0) break;
    end
    checks++; if (hi != 2) begin failures++; $display("FAIL nonseq_cs_high got=%0d exp=2", hi); end
    wait_resp(200, k, got_ack, got_err, got_dat);
    idle();
    checks++; if (got_ack !== 1'b1 || got_dat !== 8'h20) begin failures++; $display("FAIL nonseq_second got=%h exp=20", got_dat); end
    checks++; if (mosi_log.size() != 10) begin failures++; $display("FAIL nonseq_bytes got=%0d exp=10", mosi_log.size()); end
    checks++; if ({mosi_log[5], mosi_log[6], mosi_log[7], mosi_log[8]} !== 32'h03000020) begin
      failures++; $display("FAIL nonseq_header got=%h%h%h%h exp=03000020", mosi_log[5], mosi_log[6], mosi_log[7], mosi_log[8]); end
    settle();
  endtask

  task automatic test_wrap();
    req(1'b0, 24'hFFFFFF, 8'h00, 3'b010, 1'b1);
    wait_resp(200, k, got_ack, got_err, got_dat);
    checks++; if (k != 80 || got_dat !== 8'hFF) begin failures++; $display("FAIL wrap_first got=%h@%0d exp=ff@80", got_dat, k); end
    snap = cs_rises;
    req(1'b0, 24'h000000, 8'h00, 3'b111, 1'b1);
    @(posedge clk_i); #1;
    checks++; if (spi_cs_n_o !== 1'b1 || cs_rises != snap + 1) begin failures++; $display("FAIL wrap_deselect got=%b exp=1", spi_cs_n_o); end
    wait_resp(200, k, got_ack, got_err, got_dat);
    idle();
    checks++; if (got_ack !== 1'b1 || got_dat !== 8'h00) begin failures++; $display("FAIL wrap_second got=%b/%h exp=1/00", got_ack, got_dat); end
    checks++; if ({mosi_log[5], mosi_log[6], mosi_log[7], mosi_log[8]} !== 32'h03000000) begin
      failures++; $display("FAIL wrap_header got=%h%h%h%h exp=03000000", mosi_log[5], mosi_log[6], mosi_log[7], mosi_log[8]); end
    settle();
  endtask

  task automatic test_reset_mid();
    req(1'b0, 24'h000200, 8'h00, 3'b000, 1'b1);
    repeat (30) @(posedge clk_i);
    #1;
    checks++; if (spi_cs_n_o !== 1'b0) begin failures++; $display("FAIL mid_active got=%b exp=0", spi_cs_n_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (spi_cs_n_o !== 1'b1 || spi_sck_o !== 1'b0) begin failures++; $display("FAIL mid_reset_pins got=%b%b exp=10", spi_cs_n_o, spi_sck_o); end
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL mid_reset_ack got=%b exp=0", wb_ack_o); end
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    settle();
    req(1'b0, 24'h000123, 8'h00, 3'b000, 1'b1);
    wait_resp(200, k, got_ack, got_err, got_dat);
    idle();
    checks++; if (k != 80 || got_dat !== 8'hA5) begin failures++; $display("FAIL mid_recover got=%h@%0d exp=a5@80", got_dat, k); end
    checks++; if ({mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3]} !== 32'h03000123) begin
      failures++; $display("FAIL mid_header got=%h%h%h%h exp=03000123", mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3]); end
    settle();
  endtask

  initial begin
    mem[32'h00000123] = 8'hA5;
    test_reset();
    test_err();
    test_single_read();
    test_single_write();
    test_burst_read();
    test_nonseq();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_spi_sram.md
# wb_spi_sram

Wishbone slave that services the interconnect's external-memory slave port by converting each Wishbone access into a serial SRAM transaction. The serial SRAM is a 23LC1024-class device in sequential mode with 24-bit addressing, driven over SPI mode 0. Incrementing Wishbone bursts stream consecutive bytes under a single chip-select, without re-sending command and address. The block sits between the interconnect's slave 1 port and the chip's SPI pins.

## Interface
- ADDR_WIDTH, 24, Wishbone/SRAM address width; must be 24
- DATA_WIDTH, 8, data width; must be 8 (sel width 1)
- READ_CMD, 8'h03, SRAM read opcode
- WRITE_CMD, 8'h02, SRAM write opcode
- CS_HIGH_CYCLES, 2, minimum clk_i cycles spi_cs_n_o stays high between transactions

Ports:
- clk_i  in  1  clock; one clock, all logic on the rising edge
- rst_ni  in  1  reset; asynchronous assert, active-low
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write enable
- wb_adr_i  in  24  byte address
- wb_sel_i  in  1  byte select
- wb_dat_i  in  8  write data
- wb_cti_i  in  3  cycle type; 010 = incrementing, 111 = end of burst
- wb_bte_i  in  2  burst type; only 00 (linear) is streamed
- wb_ack_o, wb_err_o, wb_rty_o  out  1 each  acknowledge, error, retry (rty_o tied 0)
- wb_dat_o  out  8  read data, valid while wb_ack_o=1
- spi_sck_o, spi_cs_n_o, spi_mosi_o  out  1 each  SPI clock, chip select (low active), MOSI
- spi_miso_i  in  1  SPI MISO

## Operation
- **Reset values.** All outputs are registered. While rst_ni=0, outputs are forced immediately: ack/err/rty/dat_o=0, sck=0, cs_n=1, mosi=0. The FSM resets to IDLE.
- **FSM states:** IDLE, SHIFT, ACK, BURST_WAIT, DESELECT.
- **IDLE.**
  - On cyc&stb with sel_i=0: pulse wb_err_o for 1 cycle. No SPI activity. Stay in IDLE.
  - On cyc&stb with sel_i=1: latch we, adr and dat, load a 40-bit shift register with {cmd, adr} followed by data (or 8 don't-care bits for a read), pull cs_n low, go to SHIFT with a bit count of 40.
- **SHIFT.**
  - Each bit takes 2 clk cycles: a low phase (sck=0, mosi=current bit), then a high phase (sck=1).
  - MISO is sampled on the clk edge that ends each high phase. Bits are MSB first.
  - When the last bit completes, go to ACK.
- **ACK.** wb_ack_o=1 for exactly 1 cycle. For reads, wb_dat_o holds the last 8 sampled bits. Then:
  - If cti_i=010, bte_i=00 and adr≠24'hFFFFFF → BURST_WAIT, with cs_n held low and sck=0.
  - Otherwise → DESELECT.
- **BURST_WAIT.**
  - On cyc&stb with we equal to the latched we and adr equal to latched adr+1: load 8 data bits, go to SHIFT with a count of 8. No command or address is sent.
  - On cyc&stb that does not match, or on cyc_i=0: → DESELECT. A pending request is re-evaluated in IDLE afterwards.
  - On cyc_i=1 with stb_i=0: stay in BURST_WAIT.
- **DESELECT.** cs_n=1 for CS_HIGH_CYCLES cycles, then → IDLE.
- **Abort.** cyc_i=0 sampled in SHIFT aborts the transfer: → DESELECT, no ack.
- **Address wrap.** Burst streaming never crosses 24'hFFFFFF→0; that access is re-issued with a fresh command.

## Timing
- Let E0 be the clk edge at which IDLE samples a valid request.
- After E0: cs_n=0, sck=0, mosi=bit 39.
- Bit k occupies the low phase after E(2k) and the high phase after E(2k+1). It is sampled at E(2k+2).
- Single access: wb_ack_o is high in the cycle after E80, i.e. 80 edges after E0.
- Burst continuation sampled at edge Bn: ack is high in the cycle after Bn+16.
- With a master that updates on ack, acks arrive every 18 cycles.
- SCK frequency = clk_i/2. cs_n never toggles while sck=1.
- Reset mid-transfer: cs_n=1 immediately (asynchronous), no ack is issued, and the transaction is lost.
- sel_i=0 error: wb_err_o is high in the cycle after E0.

## Test plan
- **Single read.** Read adr 24'h000123, with the SRAM model returning 8'hA5. Required: MOSI carries 03 00 01 23, wb_ack_o is high 80 edges after E0, wb_dat_o=8'hA5, then cs_n is high for 2 cycles.
- **Single write.** Write 8'h5A to 24'h012345. Required: MOSI carries 02 01 23 45 5A, one ack at E80, and the model holds 5A at 012345.
- **Incrementing burst read.** Read 4 bytes from 24'h000010 (cti 010,010,010,111). Required: exactly one 03 00 00 10 header, cs_n stays low throughout, 4 acks returning model bytes 10..13, and cs_n rises after the 4th ack.
- **Non-sequential access mid-burst.** Read 24'h000010 with cti=010, then request 24'h000020. Required: cs_n high for 2 cycles, then a fresh header 03 00 00 20.
- **Wrap boundary.** Burst from 24'hFFFFFF with cti=010, then request 000000. Required: deselect, then a new command with address 00 00 00.
- **Error and reset cases.**
  - Request with sel_i=0: wb_err_o=1 for 1 cycle, no ack, cs_n stays 1.
  - Drive rst_ni=0 during the address phase: cs_n=1 and sck=0 immediately. A subsequent read completes normally.
